// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// State encoding, access-size codes and byte-enable patterns.
`timescale 1ns/1ps
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // True when the offset does not suit the access size.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      (size == SZ_B): m = 1'b0;
      (size == SZ_H): m = off[0];
      default:        m = (off != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and load extraction/extension.
// Purely combinational; misaligned halves/words are force-aligned.
`timescale 1ns/1ps
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [1:0]  lane;
  logic [31:0] shifted;

  // Select the lane, byte enables and replicated store data.
  always_comb begin
    lane    = 2'b00;
    be_o    = BE_W;
    wdata_o = wdata_i;
    unique case (1'b1)
      (size_i == SZ_B): begin
        lane    = off_i;
        be_o    = BE_B << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      (size_i == SZ_H): begin
        lane    = {off_i[1], 1'b0};
        be_o    = BE_H << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = mem_rdata_i >> {lane, 3'b000};

  // Sign- or zero-extend the selected load lane.
  always_comb begin
    ldata_o = shifted;
    unique case (1'b1)
      (size_i == SZ_B):
        ldata_o = uns_i ? {24'b0, shifted[7:0]}
                        : {{24{shifted[7]}}, shifted[7:0]};
      (size_i == SZ_H):
        ldata_o = uns_i ? {16'b0, shifted[15:0]}
                        : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/BUS/DONE handshake with bus timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses.
`timescale 1ns/1ps
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        trap, accept, in_bus;
  logic [31:0] ldata;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned(req_size, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign accept = (state_q == S_IDLE) && req_valid;
  assign in_bus = (state_q == S_BUS);

  lsu_align u_align (
    .size_i      (size_q),
    .uns_i       (uns_q),
    .off_i       (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .mem_rdata_i (mem_rdata),
    .be_o        (mem_be),
    .wdata_o     (mem_wdata),
    .ldata_o     (ldata)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: ack wins over a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_valid) state_d = trap ? S_DONE : S_BUS;
      S_BUS:  if (mem_ack || cnt_q == LAST) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for request, counter and result registers.
  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    unique case (1'b1)
      accept: begin
        cnt_d   = '0;
        we_d    = req_we;
        size_d  = req_size;
        uns_d   = req_unsigned;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        fault_d = trap;
        if (trap) rdata_d = '0;
      end
      in_bus: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ack) begin
          rdata_d = we_q ? '0 : ldata;
          fault_d = 1'b0;
        end else if (cnt_q == LAST) begin
          rdata_d = '0;
          fault_d = 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_W;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Outputs decoded from state; stall forced low under reset.
  always_comb begin
    mem_req  = in_bus;
    mem_we   = in_bus && we_q;
    mem_addr = {addr_q[31:2], 2'b00};
    stall    = reset && (accept || in_bus);
    done     = (state_q == S_DONE);
    fault    = done && fault_q;
    rdata    = rdata_q;
  end

endmodule
